// File: rtl/serie_paralelo_if.sv
// Serial link between the paralelo-serial transmitter and the serie_paralelo receiver.
// The master drives the serial bit; the slave (the receiver) drives the recovered byte outputs.
interface serie_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  modport master (output data_in, input data_out, valid_out, active, byte_strobe);
  modport slave  (input data_in, output data_out, valid_out, active, byte_strobe);
endinterface

// File: rtl/serie_paralelo.sv
// Serial-to-parallel receiver: aligns on COMMA, locks after LOCK_COUNT aligned commas, emits bytes.
// Optional feature: define SP_REALIGN_EN to re-align on a misaligned COMMA while ACTIVE.
module serie_paralelo #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic            clk_8f,
  input  logic            reset,
  serie_paralelo_if.slave sp
);
  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

  // One spare count value so the increment never wraps below LOCK_COUNT.
  localparam int CW = $clog2(LOCK_COUNT + 2);

  state_t        state;
  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] comma_cnt;

  logic [7:0]    win;
  logic          is_comma;
  logic          boundary;
  logic [CW-1:0] cnt_nxt;

  assign win      = {sr[6:0], sp.data_in};
  assign is_comma = (win == COMMA);
  assign boundary = (bit_cnt == 3'd7);
  assign cnt_nxt  = comma_cnt + 1'b1;

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state          <= SEARCH;
      sr             <= '0;
      bit_cnt        <= '0;
      comma_cnt      <= '0;
      sp.data_out    <= '0;
      sp.valid_out   <= 1'b0;
      sp.active      <= 1'b0;
      sp.byte_strobe <= 1'b0;
    end else begin
      sr             <= win;
      sp.byte_strobe <= 1'b0;
      case (state)
        SEARCH: begin
          if (is_comma) begin
            bit_cnt   <= '0;
            comma_cnt <= CW'(1);
            if (LOCK_COUNT == 1) begin
              state     <= ACTIVE;
              sp.active <= 1'b1;
            end else begin
              state <= LOCKING;
            end
          end
        end
        LOCKING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              comma_cnt <= cnt_nxt;
              if (cnt_nxt >= CW'(LOCK_COUNT)) begin
                state     <= ACTIVE;
                sp.active <= 1'b1;
              end
            end else begin
              // Any non-comma during lock discards all accumulated credit.
              state     <= SEARCH;
              comma_cnt <= '0;
              bit_cnt   <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            sp.byte_strobe <= 1'b1;
            if (is_comma) begin
              sp.valid_out <= 1'b0;
            end else begin
              sp.data_out  <= win;
              sp.valid_out <= 1'b1;
            end
          end
`ifdef SP_REALIGN_EN
          else if (is_comma) begin
            // Comma seen off the frame boundary: restart locking at the new offset.
            bit_cnt        <= '0;
            comma_cnt      <= CW'(1);
            state          <= LOCKING;
            sp.active      <= 1'b0;
            sp.valid_out   <= 1'b0;
            sp.byte_strobe <= 1'b0;
          end
`endif
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_serie_paralelo.sv
// Randomized scoreboard bench for serie_paralelo against a bit-history reference model.
// The model frames bytes by elapsed cycles since the last alignment point.
module tb_serie_paralelo;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         LC    = 4;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       a;
    logic       s;
  } exp_t;

  logic clk_8f = 1'b0;
  logic reset  = 1'b0;

  serie_paralelo_if sp ();

  serie_paralelo #(.COMMA(COMMA), .LOCK_COUNT(LC)) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .sp     (sp.slave)
  );

  always #5 clk_8f = ~clk_8f;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  // Reference model state: 0 = hunting, 1 = locking, 2 = locked
  bit     hist[$];
  int     mode = 0;
  longint t = 0;
  longint ta = 0;
  int     commas = 0;
  exp_t   e = '{d: 8'h00, v: 1'b0, a: 1'b0, s: 1'b0};

  task automatic step(input bit b, input bit rst_n);
    int  w;
    bit  bnd;
    @(negedge clk_8f);
    sp.data_in = b;
    reset      = rst_n;
    t++;
    e.s = 1'b0;
    if (!rst_n) begin
      hist.delete();
      mode   = 0;
      commas = 0;
      e      = '{d: 8'h00, v: 1'b0, a: 1'b0, s: 1'b0};
    end else begin
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
      w = 0;
      foreach (hist[i]) w = (w * 2 + int'(hist[i])) % 256;
      bnd = (mode != 0) && (t > ta) && ((t - ta) % 8 == 0);
      if (mode == 0) begin
        if (w == int'(COMMA)) begin
          ta = t; commas = 1;
          mode = (LC == 1) ? 2 : 1;
          if (mode == 2) e.a = 1'b1;
        end
      end else if (mode == 1) begin
        if (bnd) begin
          if (w == int'(COMMA)) begin
            commas++;
            if (commas >= LC) begin mode = 2; e.a = 1'b1; end
          end else begin
            mode = 0; commas = 0;
          end
        end
      end else begin
        if (bnd) begin
          e.s = 1'b1;
          if (w == int'(COMMA)) e.v = 1'b0;
          else begin e.d = 8'(w); e.v = 1'b1; end
        end
`ifdef SP_REALIGN_EN
        else if (w == int'(COMMA)) begin
          ta = t; commas = 1; mode = 1;
          e.a = 1'b0; e.v = 1'b0;
        end
`endif
      end
    end
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(COMMA);
  endtask

  // Monitor: compare every registered output one step after each edge with a pending expectation.
  always @(posedge clk_8f) begin
    #1;
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      n_cmp++;
      if (sp.data_out !== x.d || sp.valid_out !== x.v || sp.active !== x.a || sp.byte_strobe !== x.s) begin
        n_bad++;
        $display("FAIL outputs @%0t: got d=%h v=%b a=%b s=%b, want d=%h v=%b a=%b s=%b",
                 $time, sp.data_out, sp.valid_out, sp.active, sp.byte_strobe, x.d, x.v, x.a, x.s);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

  initial begin
    int r;
    sp.data_in = 1'b0;
    // Reset with data_in held high
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    // Lock then first data byte
    send_commas(4);
    send_byte(8'h01);
    // Aborted lock then clean relock
    step(1'b0, 1'b0);
    send_commas(2); send_byte(8'h55); send_commas(4);
    // Idle between data bytes
    send_byte(8'h0A); send_byte(COMMA); send_byte(8'h0B);
    // Reset mid-byte, then fresh lock
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    send_byte(8'h33); send_commas(4); send_byte(8'hC3);
    // Three-bit slip followed by comma stream
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    send_commas(6); send_byte(8'h5A); send_byte(8'hA5);
    // Randomized traffic with slips, idles and resets
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 25) send_commas($urandom_range(1, 6));
      else if (r < 30) begin
        for (int j = $urandom_range(1, 7); j > 0; j--) step(1'($urandom_range(0, 1)), 1'b1);
      end else if (r < 32) begin
        for (int j = $urandom_range(1, 3); j > 0; j--) step(1'($urandom_range(0, 1)), 1'b0);
      end else send_byte(8'($urandom_range(0, 255)));
    end
    @(negedge clk_8f);
    @(negedge clk_8f);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
